pattern_sched: RTL and testbench

PATTERN_SCHED -- requirements
Module: pattern_sched

---
 rtl/pattern_sched_pkg.sv | 25 ++
 rtl/pattern_sched_rr_arbiter.sv | 42 ++++
 rtl/pattern_sched.sv | 131 +++++++++++++
 tb/tb_pattern_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_sched_pkg.sv
// Shared types and constants for the bit-serial pattern scheduler.
package pattern_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SHIFT,
        ST_DRAIN,
        ST_REPORT
    } state_t;

    localparam int NREQ_DEF      = 4;
    localparam int WORD_W_DEF    = 16;
    localparam int DRAIN_CYC_DEF = 2;
    localparam int CNT_W         = 4;

    // Detector symbol encoding on det_d_o.
    localparam logic BIT_B = 1'b1;
    localparam logic BIT_C = 1'b0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pattern_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner on en.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] k;
    logic             found;

    // Scan starting at ptr, wrapping, first requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_sched.sv
// Time-shares one bit-serial BBCBC detector among NREQ requesters; reports a hit count per word.
module pattern_sched
    import pattern_sched_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    localparam int ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*WORD_W-1:0] word_i,
    output logic [NREQ-1:0]        ack_o,
    output logic                   busy_o,
    output logic                   det_clr_o,
    output logic                   det_d_o,
    output logic                   det_valid_o,
    input  logic                   det_hit_i,
    output logic                   result_valid_o,
    output logic [ID_W-1:0]        result_id_o,
    output logic [CNT_W-1:0]       result_cnt_o
);

    localparam int CYC_MAX = (WORD_W > DRAIN_CYC) ? WORD_W : DRAIN_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    state_t            state, state_nx;
    logic [CYC_W-1:0]  cyc, cyc_nx;
    logic [CNT_W-1:0]  hits, hits_nx;
    logic [WORD_W-1:0] sreg;
    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   id_q;
    logic              grant_en;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_i),
        .en    (grant_en),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    always_comb begin
        state_nx = state;
        cyc_nx   = cyc;
        hits_nx  = hits;
        grant_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req_i) begin
                    grant_en = 1'b1;
                    state_nx = ST_CLR;
                end
            end
            ST_CLR: begin
                state_nx = ST_SHIFT;
                cyc_nx   = '0;
                hits_nx  = '0;
            end
            ST_SHIFT: begin
                if (det_hit_i) hits_nx = sat_inc(hits);
                if (cyc == CYC_W'(WORD_W - 1)) begin
                    cyc_nx   = '0;
                    state_nx = (DRAIN_CYC == 0) ? ST_REPORT : ST_DRAIN;
                end else begin
                    cyc_nx = cyc + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (det_hit_i) hits_nx = sat_inc(hits);
                if (cyc == CYC_W'(DRAIN_CYC - 1)) begin
                    cyc_nx   = '0;
                    state_nx = ST_REPORT;
                end else begin
                    cyc_nx = cyc + 1'b1;
                end
            end
            ST_REPORT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cyc            <= '0;
            hits           <= '0;
            id_q           <= '0;
            ack_o          <= '0;
            busy_o         <= 1'b0;
            det_clr_o      <= 1'b0;
            det_d_o        <= 1'b0;
            det_valid_o    <= 1'b0;
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_cnt_o   <= '0;
        end else begin
            state          <= state_nx;
            cyc            <= cyc_nx;
            hits           <= hits_nx;
            if (grant_en) id_q <= gnt_idx;
            ack_o          <= grant_en ? gnt : '0;
            det_clr_o      <= grant_en;
            busy_o         <= (state_nx != ST_IDLE);
            det_valid_o    <= (state_nx == ST_SHIFT) || (state_nx == ST_DRAIN);
            det_d_o        <= (state_nx == ST_SHIFT) ? sreg[WORD_W-1] : BIT_C;
            result_valid_o <= (state_nx == ST_REPORT);
            if (state_nx == ST_REPORT) begin
                result_id_o  <= id_q;
                result_cnt_o <= hits_nx;
            end
        end
    end

    // Word shifter: loaded at grant, MSB presented first.
    always_ff @(posedge clk) begin
        if (grant_en) begin
            sreg <= word_i[gnt_idx*WORD_W +: WORD_W];
        end else if (state_nx == ST_SHIFT) begin
            sreg <= {sreg[WORD_W-2:0], BIT_C};
        end
    end

endmodule

// File: tb/tb_pattern_sched.sv
// Directed bench for pattern_sched with a stub BBCBC detector and an expected-result queue.
module tb_pattern_sched;

    localparam int WORD_W = 16;
    localparam int DRAIN  = 2;
    localparam int LAT    = 1 + WORD_W + DRAIN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_i = 4'b0;
    logic [15:0] w [4];
    logic [63:0] word_i;
    logic [3:0]  ack_o;
    logic        busy_o, det_clr_o, det_d_o, det_valid_o, det_hit_i;
    logic        result_valid_o;
    logic [1:0]  result_id_o;
    logic [3:0]  result_cnt_o;

    logic [4:0]  hist = 5'b0;
    logic        force_hit = 1'b0;

    typedef struct {
        logic [1:0] id;
        logic [3:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    int total = 0, bad = 0, cyc = 0;
    int acks_seen = 0, acks_exp = 0, ack_cyc = 0, bitpos = 0;
    bit in_word = 1'b0;
    logic [15:0] cur_word = 16'h0;

    assign word_i    = {w[3], w[2], w[1], w[0]};
    assign det_hit_i = force_hit | (hist == 5'b11010);

    pattern_sched dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .word_i         (word_i),
        .ack_o          (ack_o),
        .busy_o         (busy_o),
        .det_clr_o      (det_clr_o),
        .det_d_o        (det_d_o),
        .det_valid_o    (det_valid_o),
        .det_hit_i      (det_hit_i),
        .result_valid_o (result_valid_o),
        .result_id_o    (result_id_o),
        .result_cnt_o   (result_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub detector: last five qualified symbols, cleared by det_clr_o.
    always @(posedge clk) begin
        if (det_clr_o) hist <= 5'b0;
        else if (det_valid_o) hist <= {hist[3:0], det_d_o};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Output monitor: serial stream, ack against queue head, result pop and latency.
    always @(negedge clk) begin
        if (rst) begin
            in_word = 1'b0;
        end else begin
            if (in_word && bitpos < WORD_W + DRAIN) begin
                check("det_valid", 32'(det_valid_o), 32'd1);
                check("det_d", 32'(det_d_o),
                      (bitpos < WORD_W) ? 32'(cur_word[4'(WORD_W - 1 - bitpos)]) : 32'd0);
                bitpos++;
            end else begin
                in_word = 1'b0;
                if (det_valid_o) check("det_valid_stray", 32'(det_valid_o), 32'd0);
            end
            if (ack_o != 4'b0) begin
                acks_seen++;
                check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("ack_onehot", 32'(ack_o), 32'(4'b0001 << exp_q[0].id));
                    cur_word = w[exp_q[0].id];
                end
                check("clr_with_ack", 32'(det_clr_o), 32'd1);
                check("busy_at_ack", 32'(busy_o), 32'd1);
                in_word = 1'b1;
                bitpos  = 0;
                ack_cyc = cyc;
            end
            if (result_valid_o) begin
                check("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_id", 32'(result_id_o), 32'(e.id));
                    check("result_cnt", 32'(result_cnt_o), 32'(e.cnt));
                    check("latency", 32'(cyc - ack_cyc), 32'(LAT));
                end
            end
        end
    end

    task automatic push_exp(input int idx, input logic [3:0] cnt);
        exp_t e;
        e.id  = 2'(idx);
        e.cnt = cnt;
        exp_q.push_back(e);
        acks_exp++;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack_o == 4'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", 32'(ack_o != 4'b0), 32'd1);
    endtask

    task automatic wait_result();
        int n = 0;
        while (!result_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("result_seen", 32'(result_valid_o), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_clr", 32'(det_clr_o), 32'd0);
        check("rst_d", 32'(det_d_o), 32'd0);
        check("rst_valid", 32'(det_valid_o), 32'd0);
        check("rst_rv", 32'(result_valid_o), 32'd0);
        check("rst_id", 32'(result_id_o), 32'd0);
        check("rst_cnt", 32'(result_cnt_o), 32'd0);
    endtask

    task automatic do_word(input int idx, input logic [15:0] wd, input logic [3:0] cnt);
        w[idx] = wd;
        push_exp(idx, cnt);
        req_i = 4'(1 << idx);
        wait_ack();
        req_i = 4'b0;
        wait_result();
        @(negedge clk);
        check("busy_idle", 32'(busy_o), 32'd0);
        check("result_hold", 32'(result_cnt_o), 32'(cnt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int rv;
        for (int i = 0; i < 4; i++) w[i] = 16'h0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        do_word(0, 16'hD000, 4'd1);
        do_word(0, 16'hD680, 4'd2);
        do_word(0, 16'hFFFF, 4'd0);
        do_word(0, 16'h0000, 4'd0);

        // All four requesting continuously from a fresh pointer.
        do_reset();
        w[0] = 16'hD000; w[1] = 16'hD680; w[2] = 16'hFFFF; w[3] = 16'h1AD6;
        push_exp(0, 4'd1); push_exp(1, 4'd2); push_exp(2, 4'd0);
        push_exp(3, 4'd2); push_exp(0, 4'd1);
        req_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_ack();
            if (i == 4) req_i = 4'b0;
            wait_result();
        end
        @(negedge clk);

        // Abort mid-word with an asynchronous reset at SHIFT bit 7.
        w[1] = 16'hFFFF;
        push_exp(1, 4'd0);
        req_i = 4'b0010;
        wait_ack();
        req_i = 4'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rv = 0;
        repeat (25) begin
            @(negedge clk);
            rv += int'(result_valid_o);
        end
        check("no_report_after_abort", 32'(rv), 32'd0);
        w[0] = 16'hD000;
        push_exp(0, 4'd1);
        req_i = 4'b0011;
        wait_ack();
        req_i = 4'b0;
        wait_result();
        @(negedge clk);

        // Detector hit stuck high: count saturates.
        force_hit = 1'b1;
        do_word(2, 16'h0000, 4'd15);
        force_hit = 1'b0;

        // Hits during IDLE and CLR must not be counted.
        force_hit = 1'b1;
        repeat (3) @(negedge clk);
        w[3] = 16'h0000;
        push_exp(3, 4'd0);
        req_i = 4'b1000;
        wait_ack();
        req_i = 4'b0;
        @(posedge clk);
        #1 force_hit = 1'b0;
        wait_result();
        @(negedge clk);

        // One-cycle request in IDLE is taken; a request raised only while busy is not.
        w[2] = 16'hD000;
        push_exp(2, 4'd1);
        req_i = 4'b0100;
        @(negedge clk);
        req_i = 4'b0;
        wait_ack();
        repeat (3) @(negedge clk);
        req_i = 4'b0010;
        repeat (5) @(negedge clk);
        req_i = 4'b0;
        wait_result();
        repeat (25) @(negedge clk);

        check("ack_count", 32'(acks_seen), 32'(acks_exp));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
